// File: rtl/cpu_program_loader.sv
// Program-memory loader: assembles 12-bit words from a framed host byte stream,
// writes them into a 512x12 RAM, and serves registered instruction fetches.
module cpu_program_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_WIDTH = 12,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [ADDR_WIDTH-1:0] pc_to_program_rom,
  output logic [WORD_WIDTH-1:0] program_bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [2:0]            fsm_state
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready is registered and is low only during the single DONE cycle.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    W_HI   = 3'd3,
    W_LO   = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(DEPTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [ADDR_WIDTH-1:0]   last_idx;
  logic [7:0]              csum;
  logic [3:0]              nibble;
  logic                    accept;
  logic                    wr_en;
  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  assign accept    = rx_valid && rx_ready;
  assign wr_en     = accept && (state == W_LO);
  assign fsm_state = state;

  // RAM has no reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {nibble, rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rx_ready     <= 1'b1;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      program_bus  <= '0;
      words_loaded <= '0;
      wr_addr      <= '0;
      last_idx     <= '0;
      csum         <= 8'h00;
      nibble       <= 4'h0;
    end else begin
      // Nonblocking read gives old data on a same-address write.
      program_bus <= mem[pc_to_program_rom];
      load_done   <= 1'b0;
      if (state == DONE) begin
        state    <= IDLE;
        cpu_hold <= 1'b0;
        rx_ready <= 1'b1;
      end else if (accept) begin
        case (state)
          IDLE, ERROR: begin
            if (rx_data == 8'hA5) begin
              state        <= CNT_HI;
              cpu_hold     <= 1'b1;
              load_error   <= 1'b0;
              words_loaded <= '0;
              csum         <= 8'h00;
              wr_addr      <= '0;
            end
          end
          CNT_HI: begin
            if (rx_data[7:1] != 7'd0) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              last_idx[8] <= rx_data[0];
              csum        <= csum + rx_data;
              state       <= CNT_LO;
            end
          end
          CNT_LO: begin
            last_idx[7:0] <= rx_data;
            csum          <= csum + rx_data;
            state         <= W_HI;
          end
          W_HI: begin
            if (rx_data[7:4] != 4'd0) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              nibble <= rx_data[3:0];
              csum   <= csum + rx_data;
              state  <= W_LO;
            end
          end
          W_LO: begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            if (words_loaded != MAX_WORDS) words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
            csum  <= csum + rx_data;
            state <= (wr_addr == last_idx) ? CSUM : W_HI;
          end
          CSUM: begin
            if (rx_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              rx_ready  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: directed frame table, randomized stalled frames
// against a frame-level memory model, full-depth load, reset mid-load, collision.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [8:0]  pc;
  logic [11:0] program_bus;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [9:0]  words_loaded;
  logic [2:0]  fsm_state;

  cpu_program_loader dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .pc_to_program_rom (pc),
    .program_bus       (program_bus),
    .cpu_hold          (cpu_hold),
    .load_done         (load_done),
    .load_error        (load_error),
    .words_loaded      (words_loaded),
    .fsm_state         (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic        prev_done = 1'b0;
  logic [11:0] ref_mem [512];
  logic [7:0]  frame_q[$];
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle monitor: ready/done relation and hold release after done.
  always @(negedge clk) begin
    if (rst) begin
      check("rx_ready_low_only_in_done", rx_ready, !load_done);
      if (load_done) begin
        done_cnt++;
        check("hold_during_done", cpu_hold, 1);
      end
      if (prev_done) check("hold_release_after_done", {cpu_hold, load_done}, 0);
      prev_done = load_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Frame-level reference: parse frame_q (header first) and update ref_mem.
  task automatic model_frame(output bit done, output bit err, output int words);
    logic [7:0] b1, hi, lo, sum;
    int n;
    done = 0; err = 0; words = 0;
    b1 = frame_q[1];
    if (b1[7:1] != 7'd0) begin err = 1; return; end
    n   = (b1[0] ? 256 : 0) + int'(frame_q[2]) + 1;
    sum = b1 + frame_q[2];
    for (int i = 0; i < n; i++) begin
      hi = frame_q[3 + 2*i];
      if (hi[7:4] != 4'd0) begin err = 1; return; end
      lo = frame_q[4 + 2*i];
      ref_mem[i] = {hi[3:0], lo};
      words++;
      sum = sum + hi + lo;
    end
    if (frame_q[3 + 2*n] == sum) done = 1;
    else err = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int max_stall);
    int stall, tries;
    stall = (max_stall > 0) ? int'($urandom_range(max_stall)) : 0;
    @(negedge clk);
    if (stall > 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (stall) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    while (!rx_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input int max_stall, input bit e_done,
                           input bit e_err, input int e_words);
    int start;
    start = done_cnt;
    send_byte(frame_q[0], max_stall);
    #1;
    check({name, "_hold_after_hdr"}, cpu_hold, 1);
    check({name, "_err_clr_on_hdr"}, load_error, 0);
    for (int k = 1; k < frame_q.size(); k++) send_byte(frame_q[k], max_stall);
    idle_bus();
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - start, e_done ? 1 : 0);
    check({name, "_load_error"}, load_error, e_err);
    check({name, "_words_loaded"}, words_loaded, e_words);
    check({name, "_cpu_hold"}, cpu_hold, !e_done);
  endtask

  task automatic fetch_check(input logic [8:0] a, input logic [11:0] exp, input string name);
    @(negedge clk);
    pc = a;
    @(negedge clk);
    check(name, program_bus, exp);
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      if (exp_q.size() > 0) check($sformatf("fetch_sweep_%0d", a - 1), program_bus, exp_q.pop_front());
      if (a <= hi) begin
        pc = 9'(a);
        exp_q.push_back(ref_mem[a]);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [95:0] b;
    int          len;
    bit          e_done;
    bit          e_err;
    int          e_words;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit   m_done, m_err;
    int   m_words, n, kind, k;
    logic [11:0] w, old0;
    logic [7:0]  hb, sum;

    vecs[0] = '{{8'hA5,8'h00,8'h01,8'h01,8'h23,8'h0F,8'hFF,8'h33,32'h0}, 8, 1, 0, 2};
    vecs[1] = '{{8'hA5,8'h00,8'h01,8'h01,8'h23,8'h0F,8'hFF,8'h34,32'h0}, 8, 0, 1, 2};
    vecs[2] = '{{8'hA5,8'h00,8'h01,8'h01,8'h23,8'h0F,8'hFF,8'h33,32'h0}, 8, 1, 0, 2};
    vecs[3] = '{{8'hA5,8'h00,8'h01,8'h10,8'h23,8'h33,48'h0}, 6, 0, 1, 0};
    vecs[4] = '{{8'hA5,8'h02,8'h00,8'h01,8'h23,56'h0}, 5, 0, 1, 0};
    vecs[5] = '{{8'hA5,8'h00,8'h00,8'h0A,8'hA5,8'hAF,48'h0}, 6, 1, 0, 1};
    vecs[6] = '{{8'hA5,8'h00,8'h00,8'h0F,8'h00,8'h0F,48'h0}, 6, 1, 0, 1};

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = 9'd0;
    repeat (3) @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_program_bus", program_bus, 12'h000);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_state_idle", fsm_state, 3'd0);
    rst = 1'b1;

    // Directed frames, back-to-back.
    for (int i = 0; i < 7; i++) begin
      frame_q.delete();
      for (int j = 0; j < vecs[i].len; j++) frame_q.push_back(vecs[i].b[95 - 8*j -: 8]);
      run_frame($sformatf("vec%0d", i), 0, vecs[i].e_done, vecs[i].e_err, vecs[i].e_words);
      model_frame(m_done, m_err, m_words);
      if (i == 0) begin
        fetch_check(9'd1, 12'hFFF, "vec0_fetch_pc1");
        fetch_check(9'd0, 12'h123, "vec0_fetch_pc0");
      end
    end
    sweep(0, 1);

    // Randomized frames with stalls and junk bytes between them.
    send_byte(8'h00, 2);
    send_byte(8'h5A, 2);
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(3)) begin
        hb = 8'($urandom);
        if (hb == 8'hA5) hb = 8'h5A;
        send_byte(hb, 2);
      end
      frame_q.delete();
      n    = $urandom_range(24, 1);
      kind = $urandom_range(3);
      k    = $urandom_range(n - 1);
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'((n - 1) >> 8));
      frame_q.push_back(8'((n - 1) & 255));
      sum = frame_q[1] + frame_q[2];
      for (int i = 0; i < n; i++) begin
        w  = 12'($urandom);
        hb = {4'h0, w[11:8]};
        if (kind == 1 && i == k) begin
          hb[7:4] = 4'($urandom_range(15, 1));
          frame_q.push_back(hb);
          break;
        end
        frame_q.push_back(hb);
        frame_q.push_back(w[7:0]);
        sum = sum + hb + w[7:0];
      end
      if (kind != 1) frame_q.push_back((kind == 0) ? sum + 8'd1 : sum);
      model_frame(m_done, m_err, m_words);
      run_frame($sformatf("rand%0d", r), 3, m_done, m_err, m_words);
      if (m_words > 0) sweep(0, m_words - 1);
    end

    // Full-depth frame: word i = i.
    frame_q.delete();
    frame_q.push_back(8'hA5); frame_q.push_back(8'h01); frame_q.push_back(8'hFF);
    sum = 8'h01 + 8'hFF;
    for (int i = 0; i < 512; i++) begin
      frame_q.push_back(8'(i >> 8));
      frame_q.push_back(8'(i & 255));
      sum = sum + 8'(i >> 8) + 8'(i & 255);
    end
    frame_q.push_back(sum);
    model_frame(m_done, m_err, m_words);
    run_frame("full512", 0, 1, 0, 512);
    fetch_check(9'd511, 12'h1FF, "full512_mem511");
    sweep(0, 511);

    // Reset after 3 of 5 words.
    frame_q.delete();
    frame_q.push_back(8'hA5); frame_q.push_back(8'h00); frame_q.push_back(8'h04);
    sum = 8'h04;
    for (int i = 1; i <= 5; i++) begin
      w = 12'(12'h111 * i);
      frame_q.push_back({4'h0, w[11:8]});
      frame_q.push_back(w[7:0]);
      sum = sum + {4'h0, w[11:8]} + w[7:0];
    end
    frame_q.push_back(sum);
    model_frame(m_done, m_err, m_words);
    run_frame("pre_reset", 0, 1, 0, 5);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    for (int i = 1; i <= 3; i++) begin
      send_byte(8'h0A, 1);
      send_byte(8'(i), 1);
      ref_mem[i - 1] = 12'hA00 + 12'(i);
    end
    idle_bus();
    #2 rst = 1'b0;
    #1;
    check("midload_rst_cpu_hold", cpu_hold, 0);
    check("midload_rst_state_idle", fsm_state, 3'd0);
    check("midload_rst_words", words_loaded, 0);
    check("midload_rst_bus", program_bus, 12'h000);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h00, 1);
    send_byte(8'h0A, 1);
    send_byte(8'h01, 1);
    idle_bus();
    repeat (2) @(negedge clk);
    check("post_rst_junk_hold", cpu_hold, 0);
    check("post_rst_junk_state", fsm_state, 3'd0);
    sweep(0, 4);

    // Same-address write and fetch returns old data first.
    old0 = ref_mem[0];
    @(negedge clk);
    pc = 9'd0;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h07, 0); send_byte(8'hE7, 0);
    #1 check("collision_old_data", program_bus, old0);
    send_byte(8'hEE, 0);
    #1 check("collision_new_data", program_bus, 12'h7E7);
    idle_bus();
    frame_q.delete();
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h07, 8'hE7, 8'hEE};
    model_frame(m_done, m_err, m_words);
    repeat (3) @(negedge clk);
    check("collision_words", words_loaded, 1);
    check("collision_hold", cpu_hold, 0);
    sweep(0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Write side of the CPU program memory, paired with the fetch side in the instruction datapath.
- Receives a framed byte stream from a host link (UART receiver or test bench) and assembles 12-bit instruction words.
- Writes the words into a 512 x 12 program RAM and holds the CPU while a load is in progress.
- Also serves instruction fetches: the CPU supplies the PC address, and the block returns the 12-bit word on the program bus.

Parameters:
- ADDR_WIDTH, 9, program address width (matches PC width).
- WORD_WIDTH, 12, instruction width.
- DEPTH, 512, number of program words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming host byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
- pc_to_program_rom  input  9  fetch address from the PC.
- program_bus  output  12  fetched instruction, registered.
- cpu_hold  output  1  CPU must stall/hold reset while high.
- load_done  output  1  one-cycle pulse when a frame completes with a good checksum.
- load_error  output  1  sticky error flag; cleared by the next header byte or by reset.
- words_loaded  output  10  number of words written in the current or most recent frame.

Behaviour:
- Reset (rst=0, async) sets:
  - state IDLE;
  - cpu_hold=0, load_done=0, load_error=0;
  - program_bus=12'h000, words_loaded=0;
  - write address=0, checksum accumulator=0.
  RAM contents are not cleared. Reset mid-load keeps the words already written.
- Fetch: program_bus <= mem[pc_to_program_rom] every cycle, giving 1-cycle latency. Fetch is active in every state.
- Write/read collision: if a write and a fetch hit the same address in the same cycle, program_bus returns the old data.
- Frame format:
  - 0xA5 header;
  - CNT_HI (bits 7:1 must be 0, bit 0 = (N-1)[8]);
  - CNT_LO = (N-1)[7:0], where N = 1..512;
  - then N words, each sent as two bytes, WHI then WLO:
    - WHI carries word[11:8] in bits 3:0; bits 7:4 must be 0;
    - WLO carries word[7:0];
  - then CSUM = sum mod 256 of every byte after the header (CNT_HI through the last WLO).
- rx_ready=1 in all states except DONE.
- State machine (transitions occur only on an accepted byte unless noted):
  - IDLE: byte 0xA5 -> CNT_HI, and sets cpu_hold=1, words_loaded=0, checksum=0, wr_addr=0. Any other byte is dropped.
  - CNT_HI: bits 7:1 nonzero -> ERROR; else latch bit 0, accumulate checksum -> CNT_LO.
  - CNT_LO: latch, accumulate -> W_HI.
  - W_HI: bits 7:4 nonzero -> ERROR; else latch nibble, accumulate -> W_LO.
  - W_LO: write mem[wr_addr] <= {nibble, byte}, increment wr_addr and words_loaded, accumulate. If this was word N -> CSUM, else -> W_HI.
  - CSUM: byte == accumulator -> DONE; else -> ERROR.
  - DONE: lasts one cycle, no byte accepted. load_done=1, cpu_hold stays 1. Unconditionally -> IDLE, where cpu_hold deasserts; cpu_hold first reads 0 in the cycle after load_done.
  - ERROR: load_error=1, cpu_hold stays 1. Byte 0xA5 -> CNT_HI and clears load_error. Other bytes are dropped.
- Counts and widths:
  - N=512 writes addresses 0..511; wr_addr wraps to 0 only after the last word and is never reused within a frame.
  - words_loaded saturates at 512.
  - The checksum is an 8-bit modular sum.
- A 0xA5 byte arriving inside a frame is treated as data, not as a new header.
- All outputs are registered.

Test Plan:
- Load frame A5 00 01 | 01 23 | 0F FF | CSUM=0x33 -> mem[0]=12'h123, mem[1]=12'hFFF. load_done pulses once, words_loaded=2, cpu_hold high from the cycle after A5 until the cycle after load_done. Then pc=1 -> program_bus=12'hFFF one cycle later.
- Same frame with CSUM=0x34 -> load_error=1, cpu_hold stays 1, no load_done. Then a good frame -> load_error clears on its A5 and load_done pulses.
- WHI byte 0x10 -> ERROR immediately, remaining bytes ignored until 0xA5. Likewise CNT_HI=0x02 -> ERROR.
- Full 512-word frame (count bytes 01 FF), word i = i -> mem[511]=12'h1FF, words_loaded=512, load_done pulses. A fetch sweep of pc 0..511 returns matching data with 1-cycle latency.
- Reset asserted after 3 of 5 words -> cpu_hold=0 and state IDLE asynchronously. mem[0..2] hold the new words, mem[3..4] keep their old contents. Bytes other than 0xA5 are dropped after reset.
- Stalled handshake: rx_valid toggled 0/1 randomly during a frame, plus junk bytes (0x00, 0x5A) while in IDLE -> identical memory result to the back-to-back case, and rx_ready=0 only in the DONE cycle.
